// File: rtl/calc_result_display.sv
// Sign-magnitude result sink driving two multiplexed active-low 7-segment digits.
// Optional blink-on-capture sequence enabled by defining CALC_DISP_BLINK_EN.
module calc_result_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic       res_sign,
    input  logic [2:0] res_mag,
    input  logic       res_zero,
    input  logic       disp_en,
    output logic [6:0] seg_n,
    output logic [1:0] an_n,
    output logic       shown_valid
);

    localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t      state, state_nx;
    logic [DW-1:0] div, div_nx;
    logic        slot, slot_nx;
    logic        h_sign, h_sign_nx;
    logic        h_zero, h_zero_nx;
    logic [2:0]  h_mag, h_mag_nx;
    logic        cap;
    logic        blink_off;
    logic        dark;
    logic [6:0]  seg_nx;
    logic [1:0]  an_nx;

    function automatic logic [6:0] digit(input logic [2:0] m);
        case (m)
            3'd0:    digit = 7'h40;
            3'd1:    digit = 7'h79;
            3'd2:    digit = 7'h24;
            3'd3:    digit = 7'h30;
            3'd4:    digit = 7'h19;
            3'd5:    digit = 7'h12;
            3'd6:    digit = 7'h02;
            default: digit = 7'h78;
        endcase
    endfunction

    // Outputs are registered from next-state values, so a capture or slot
    // change is visible on the pins right after the edge that causes it.
    always_comb begin
        cap       = res_valid && res_ready;
        div_nx    = (div == DIV_MAX) ? '0 : div + DW'(1);
        slot_nx   = (div == DIV_MAX) ? ~slot : slot;
        state_nx  = cap ? SHOW : state;
        h_sign_nx = cap ? res_sign : h_sign;
        h_mag_nx  = cap ? res_mag  : h_mag;
        h_zero_nx = cap ? res_zero : h_zero;
        dark      = (state_nx == BLANK) || !disp_en || blink_off;
        seg_nx    = 7'h7F;
        an_nx     = 2'b11;
        if (!dark) begin
            if (!slot_nx) begin
                an_nx  = 2'b10;
                seg_nx = digit(h_mag_nx);
            end else if (h_sign_nx && !(h_zero_nx || h_mag_nx == 3'd0)) begin
                an_nx  = 2'b01;
                seg_nx = 7'h3F;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= BLANK;
            div    <= '0;
            slot   <= 1'b0;
            h_sign <= 1'b0;
            h_mag  <= 3'd0;
            h_zero <= 1'b0;
            seg_n  <= 7'h7F;
            an_n   <= 2'b11;
        end else begin
            state  <= state_nx;
            div    <= div_nx;
            slot   <= slot_nx;
            h_sign <= h_sign_nx;
            h_mag  <= h_mag_nx;
            h_zero <= h_zero_nx;
            seg_n  <= seg_nx;
            an_n   <= an_nx;
        end
    end

    assign shown_valid = (state == SHOW);

`ifdef CALC_DISP_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    logic          blink_act, blink_act_nx;
    logic [BW-1:0] blink_cnt, blink_cnt_nx;
    logic [2:0]    blink_ph, blink_ph_nx;

    // Six phases, even ones dark; input is refused until the last phase ends.
    always_comb begin
        blink_act_nx = blink_act;
        blink_cnt_nx = blink_cnt;
        blink_ph_nx  = blink_ph;
        if (cap) begin
            blink_act_nx = 1'b1;
            blink_cnt_nx = '0;
            blink_ph_nx  = 3'd0;
        end else if (blink_act) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt_nx = '0;
                if (blink_ph == 3'd5) blink_act_nx = 1'b0;
                else                  blink_ph_nx  = blink_ph + 3'd1;
            end else begin
                blink_cnt_nx = blink_cnt + BW'(1);
            end
        end
        blink_off = blink_act_nx && !blink_ph_nx[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_act <= 1'b0;
            blink_cnt <= '0;
            blink_ph  <= 3'd0;
            res_ready <= 1'b1;
        end else begin
            blink_act <= blink_act_nx;
            blink_cnt <= blink_cnt_nx;
            blink_ph  <= blink_ph_nx;
            res_ready <= !blink_act_nx;
        end
    end
`else
    assign res_ready = 1'b1;
    assign blink_off = 1'b0;
`endif

endmodule

// File: tb/tb_calc_result_display.sv
// Scoreboard bench for calc_result_display with REFRESH_DIV=4, BLINK_CYCLES=8.
module tb_calc_result_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic       res_sign = 1'b0;
    logic [2:0] res_mag = 3'd0;
    logic       res_zero = 1'b0;
    logic       disp_en = 1'b1;
    logic [6:0] seg_n;
    logic [1:0] an_n;
    logic       shown_valid;

    calc_result_display #(.REFRESH_DIV(4), .BLINK_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
        .res_sign(res_sign), .res_mag(res_mag), .res_zero(res_zero),
        .disp_en(disp_en), .seg_n(seg_n), .an_n(an_n), .shown_valid(shown_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [6:0] seg;
        logic [1:0] an;
        logic       sv;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    exp_t got;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [6:0] segtab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    // Reference state: scan position, held value, blink sequence.
    int         mdiv = 0;
    logic       mslot = 1'b0;
    logic       mshow = 1'b0;
    logic       ms = 1'b0;
    logic       mz = 1'b0;
    logic [2:0] mm = 3'd0;
    logic       bact = 1'b0;
    int         bcnt = 0;
    int         bph = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            got = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missed_sample due=%0d now=%0d", got.due, cyc);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            got = q.pop_front();
            n_vec++;
            if (seg_n !== got.seg || an_n !== got.an || shown_valid !== got.sv || res_ready !== got.rdy) begin
                n_err++;
                $display("FAIL scan cyc=%0d got seg=%h an=%b sv=%b rdy=%b, want seg=%h an=%b sv=%b rdy=%b",
                         cyc, seg_n, an_n, shown_valid, res_ready, got.seg, got.an, got.sv, got.rdy);
            end
        end
    end

    task automatic model_reset();
        mdiv = 0; mslot = 1'b0; mshow = 1'b0; ms = 1'b0; mz = 1'b0; mm = 3'd0;
        bact = 1'b0; bcnt = 0; bph = 0;
    endtask

    task automatic chk_reset(input string name);
        n_vec++;
        if (seg_n !== 7'h7F || an_n !== 2'b11 || shown_valid !== 1'b0 || res_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s got seg=%h an=%b sv=%b rdy=%b, want seg=7f an=11 sv=0 rdy=1",
                     name, seg_n, an_n, shown_valid, res_ready);
        end
    endtask

    // Drive one cycle of inputs and queue the output expected after the edge.
    task automatic tick(input logic v, input logic s, input logic [2:0] m,
                        input logic z, input logic en);
        exp_t e;
        logic cap;
        logic off;
        res_valid = v; res_sign = s; res_mag = m; res_zero = z; disp_en = en;
        cap = v && !bact;
        if (cap) begin
            mshow = 1'b1; ms = s; mm = m; mz = z;
        end
        if (mdiv == 3) begin
            mdiv = 0; mslot = ~mslot;
        end else begin
            mdiv++;
        end
`ifdef CALC_DISP_BLINK_EN
        if (cap) begin
            bact = 1'b1; bcnt = 0; bph = 0;
        end else if (bact) begin
            if (bcnt == 7) begin
                bcnt = 0;
                if (bph == 5) bact = 1'b0;
                else          bph++;
            end else begin
                bcnt++;
            end
        end
`endif
        off   = bact && (bph % 2 == 0);
        e.due = cyc + 1;
        e.sv  = mshow;
        e.rdy = !bact;
        e.an  = 2'b11;
        e.seg = 7'h7F;
        if (mshow && en && !off) begin
            if (!mslot) begin
                e.an = 2'b10; e.seg = segtab[mm];
            end else if (ms && !(mz || mm == 3'd0)) begin
                e.an = 2'b01; e.seg = 7'h3F;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0, 1'b0, en);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset is visible before the first clock edge.
        #1 rst = 1'b1;
        #1 chk_reset("reset_async");
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();

        // Dark while BLANK, then a negative five alternating with minus.
        idle(2, 1'b1);
        tick(1'b1, 1'b1, 3'd5, 1'b0, 1'b1);
        idle(10, 1'b1);

        // Zero flag and negative zero both suppress the minus; positive value never shows it.
        tick(1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
        idle(8, 1'b1);
        tick(1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
        idle(8, 1'b1);
        tick(1'b1, 1'b0, 3'd4, 1'b0, 1'b1);
        idle(8, 1'b1);

        // Display enable dropped mid-slot; scan keeps running underneath.
        tick(1'b1, 1'b0, 3'd3, 1'b0, 1'b1);
        idle(2, 1'b1);
        idle(5, 1'b0);
        idle(8, 1'b1);

        // Asynchronous reset while showing seven, then normal operation again.
        tick(1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 3'd7, 1'b0, 1'b1);
        idle(3, 1'b1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_reset("reset_mid_display");
        model_reset();
        #1 rst = 1'b0;
        idle(2, 1'b1);
        tick(1'b1, 1'b0, 3'd6, 1'b0, 1'b1);
        idle(8, 1'b1);

`ifdef CALC_DISP_BLINK_EN
        // Blink sequence: a second offer during the sequence must be ignored.
        tick(1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
        idle(10, 1'b1);
        tick(1'b1, 1'b0, 3'd6, 1'b0, 1'b1);
        idle(40, 1'b1);
        tick(1'b1, 1'b1, 3'd1, 1'b0, 1'b1);
        idle(4, 1'b1);
`endif

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
